// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - serial system-bus master: arbitrate, send mode/slave/address/data frame, collect ack or read data.
// Optional MASTER_TIMEOUT_EN aborts REQUEST/WAIT_ACK/RECV_DATA after TIMEOUT idle cycles and flags tx_error.
module bus_master_port #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int SEL_WIDTH    = 2,
  parameter int TARGET_SLAVE = 1,
  parameter int TARGET_ADDR  = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            instruction,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  tx_done,
  output logic                  tx_error,
  output logic                  bus_request,
  input  logic                  bus_grant,
  output logic                  bus_busy,
  output logic                  m_dout,
  output logic                  m_valid,
  input  logic                  s_ready,
  input  logic                  m_din,
  input  logic                  m_din_valid
);

  localparam int H  = 1 + SEL_WIDTH + ADDR_WIDTH;
  localparam int FW = H + DATA_WIDTH;
  localparam int CW = $clog2(FW + 1);
  localparam logic [CW-1:0]         H_CNT    = CW'(H);
  localparam logic [CW-1:0]         F_CNT    = CW'(FW);
  localparam logic [CW-1:0]         D_LAST   = CW'(DATA_WIDTH - 1);
  localparam logic [SEL_WIDTH-1:0]  SLAVE_ID = SEL_WIDTH'(TARGET_SLAVE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_VAL = ADDR_WIDTH'(TARGET_ADDR);

  typedef enum logic [2:0] {
    IDLE, REQUEST, SEND_HEADER, SEND_DATA, WAIT_ACK, RECV_DATA, DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  armed_q, armed_d;
  logic                  mode_q, mode_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [DATA_WIDTH-2:0] rx_q, rx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  tx_done_q, tx_done_d;
  logic                  bus_request_q, bus_request_d;
  logic                  bus_busy_q, bus_busy_d;
  logic                  m_dout_q, m_dout_d;
  logic                  m_valid_q, m_valid_d;
  logic                  shift_out, finish, abort, clr_err, timeout_hit;

  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    mode_d        = mode_q;
    frame_d       = frame_q;
    rx_d          = rx_q;
    cnt_d         = cnt_q;
    data_out_d    = data_out_q;
    tx_done_d     = 1'b0;
    bus_request_d = bus_request_q;
    bus_busy_d    = bus_busy_q;
    m_dout_d      = 1'b0;
    m_valid_d     = 1'b0;
    shift_out     = 1'b0;
    finish        = 1'b0;
    abort         = 1'b0;
    clr_err       = 1'b0;

    case (state_q)
      IDLE: begin
        if (instruction == 2'b00) begin
          armed_d = 1'b1;
        end else if (armed_q && (instruction == 2'b01 || instruction == 2'b10)) begin
          mode_d        = instruction[1];
          frame_d       = {instruction[1], SLAVE_ID, ADDR_VAL, data_in};
          cnt_d         = '0;
          clr_err       = 1'b1;
          bus_request_d = 1'b1;
          state_d       = REQUEST;
        end
      end
      REQUEST: begin
        if (bus_grant) begin
          bus_busy_d = 1'b1;
          shift_out  = 1'b1;
          state_d    = SEND_HEADER;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      SEND_HEADER: begin
        // Header complete: writes roll straight into data bits with no gap.
        if (cnt_q == H_CNT) begin
          if (mode_q) begin
            shift_out = 1'b1;
            state_d   = SEND_DATA;
          end else begin
            cnt_d   = '0;
            state_d = RECV_DATA;
          end
        end else begin
          shift_out = 1'b1;
        end
      end
      SEND_DATA: begin
        if (cnt_q == F_CNT) state_d = WAIT_ACK;
        else                shift_out = 1'b1;
      end
      WAIT_ACK: begin
        if (s_ready)          finish = 1'b1;
        else if (timeout_hit) abort  = 1'b1;
      end
      RECV_DATA: begin
        if (m_din_valid) begin
          rx_d  = {rx_q[DATA_WIDTH-3:0], m_din};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == D_LAST) begin
            data_out_d = {rx_q, m_din};
            finish     = 1'b1;
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      DONE: begin
        armed_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (shift_out) begin
      m_valid_d = 1'b1;
      m_dout_d  = frame_q[FW-1];
      frame_d   = {frame_q[FW-2:0], 1'b0};
      cnt_d     = cnt_q + CW'(1);
    end
    if (finish || abort) begin
      state_d       = DONE;
      tx_done_d     = 1'b1;
      bus_request_d = 1'b0;
      bus_busy_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      armed_q       <= 1'b1;
      mode_q        <= 1'b0;
      frame_q       <= '0;
      rx_q          <= '0;
      cnt_q         <= '0;
      data_out_q    <= '0;
      tx_done_q     <= 1'b0;
      bus_request_q <= 1'b0;
      bus_busy_q    <= 1'b0;
      m_dout_q      <= 1'b0;
      m_valid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      mode_q        <= mode_d;
      frame_q       <= frame_d;
      rx_q          <= rx_d;
      cnt_q         <= cnt_d;
      data_out_q    <= data_out_d;
      tx_done_q     <= tx_done_d;
      bus_request_q <= bus_request_d;
      bus_busy_q    <= bus_busy_d;
      m_dout_q      <= m_dout_d;
      m_valid_q     <= m_valid_d;
    end
  end

`ifdef MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tx_error_q;

  // Restarts on any state entry and on every received read bit.
  always_comb begin
    tmo_d = '0;
    if (state_d == state_q &&
        (state_q == REQUEST || state_q == WAIT_ACK || state_q == RECV_DATA) &&
        !(state_q == RECV_DATA && m_din_valid))
      tmo_d = tmo_q + TW'(1);
  end

  assign timeout_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q      <= '0;
      tx_error_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (clr_err)    tx_error_q <= 1'b0;
      else if (abort) tx_error_q <= 1'b1;
    end
  end

  assign tx_error = tx_error_q;
`else
  logic unused_err;
  assign timeout_hit = 1'b0;
  assign unused_err  = clr_err;
  assign tx_error    = 1'b0;
`endif

  assign data_out    = data_out_q;
  assign tx_done     = tx_done_q;
  assign bus_request = bus_request_q;
  assign bus_busy    = bus_busy_q;
  assign m_dout      = m_dout_q;
  assign m_valid     = m_valid_q;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - directed self-checking bench for bus_master_port.
module tb_bus_master_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] instruction = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic       bus_grant = 1'b0;
  logic       s_ready = 1'b0;
  logic       m_din = 1'b0;
  logic       m_din_valid = 1'b0;
  logic [7:0] data_out;
  logic       tx_done, tx_error, bus_request, bus_busy, m_dout, m_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_master_port #(.TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .data_in(data_in),
    .data_out(data_out), .tx_done(tx_done), .tx_error(tx_error),
    .bus_request(bus_request), .bus_grant(bus_grant), .bus_busy(bus_busy),
    .m_dout(m_dout), .m_valid(m_valid), .s_ready(s_ready),
    .m_din(m_din), .m_din_valid(m_din_valid)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Full write frame; grant dropped after bit drop_at, optional early s_ready during data bits.
  task automatic write_txn(input logic [7:0] d, input int gwait, input int drop_at,
                           input bit ack, input bit early);
    logic [22:0] fr;
    fr = {1'b1, 2'b01, 12'h000, d};
    instruction = 2'b10;
    data_in = d;
    tick;
    chk1("wr_req", bus_request, 1'b1);
    chk1("wr_busy_pre", bus_busy, 1'b0);
    data_in = ~d;
    repeat (gwait) begin
      tick;
      chk1("wr_req_hold", bus_request, 1'b1);
      chk1("wr_valid_pre", m_valid, 1'b0);
    end
    bus_grant = 1'b1;
    for (int i = 0; i < 23; i++) begin
      tick;
      if (i == drop_at) bus_grant = 1'b0;
      s_ready = early && i >= 16 && i < 22;
      chk1("wr_valid", m_valid, 1'b1);
      chk1("wr_bit", m_dout, fr[22-i]);
      chk1("wr_busy", bus_busy, 1'b1);
      chk1("wr_no_done", tx_done, 1'b0);
    end
    bus_grant = 1'b0;
    s_ready = 1'b0;
    tick;
    chk1("wr_valid_end", m_valid, 1'b0);
    chk1("wr_done_early", tx_done, 1'b0);
    if (ack) begin
      tick;
      chk1("wr_wait_busy", bus_busy, 1'b1);
      s_ready = 1'b1;
      tick;
      s_ready = 1'b0;
      chk1("wr_done", tx_done, 1'b1);
      chk1("wr_err", tx_error, 1'b0);
      chk1("wr_req_rel", bus_request, 1'b0);
      chk1("wr_busy_rel", bus_busy, 1'b0);
      tick;
      chk1("wr_done_pulse", tx_done, 1'b0);
    end
  endtask

  initial begin
    logic [14:0] hdr;
    logic [7:0]  rd;

    tick;
    chk1("rst_req", bus_request, 1'b0);
    chk1("rst_busy", bus_busy, 1'b0);
    chk1("rst_valid", m_valid, 1'b0);
    chk1("rst_dout", m_dout, 1'b0);
    chk1("rst_done", tx_done, 1'b0);
    chk1("rst_err", tx_error, 1'b0);
    chk8("rst_dout8", data_out, 8'h00);
    reset = 1'b0;
    tick;

    write_txn(8'hA5, 3, -1, 1'b1, 1'b0);

    // Instruction still 10 after tx_done: must not re-issue.
    repeat (5) begin
      tick;
      chk1("rearm_no_req", bus_request, 1'b0);
      chk1("rearm_no_valid", m_valid, 1'b0);
      chk1("rearm_no_done", tx_done, 1'b0);
    end
    instruction = 2'b00;
    tick;
    write_txn(8'h5A, 1, 4, 1'b1, 1'b1);

    instruction = 2'b00;
    tick;
    instruction = 2'b01;
    hdr = {1'b0, 2'b01, 12'h000};
    rd = 8'h3C;
    tick;
    chk1("rd_req", bus_request, 1'b1);
    bus_grant = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick;
      bus_grant = 1'b0;
      chk1("rd_valid", m_valid, 1'b1);
      chk1("rd_bit", m_dout, hdr[14-i]);
    end
    tick;
    chk1("rd_valid_end", m_valid, 1'b0);
    chk1("rd_busy", bus_busy, 1'b1);
    for (int b = 7; b >= 0; b--) begin
      m_din = rd[b];
      m_din_valid = 1'b1;
      tick;
      if (b > 0) begin
        chk1("rd_no_done", tx_done, 1'b0);
        chk8("rd_dout_old", data_out, 8'h00);
      end
      if (b == 4) begin
        m_din_valid = 1'b0;
        m_din = 1'b1;
        tick;
        tick;
        chk1("rd_gap_busy", bus_busy, 1'b1);
      end
    end
    m_din_valid = 1'b0;
    chk1("rd_done", tx_done, 1'b1);
    chk8("rd_data", data_out, 8'h3C);
    chk1("rd_err", tx_error, 1'b0);
    chk1("rd_busy_rel", bus_busy, 1'b0);
    tick;
    chk1("rd_done_pulse", tx_done, 1'b0);
    chk8("rd_data_hold", data_out, 8'h3C);

    // Reset while data bit 4 is on the wire.
    instruction = 2'b00;
    tick;
    instruction = 2'b10;
    data_in = 8'h96;
    tick;
    bus_grant = 1'b1;
    for (int i = 0; i < 20; i++) tick;
    chk1("pre_rst_valid", m_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("arst_req", bus_request, 1'b0);
    chk1("arst_busy", bus_busy, 1'b0);
    chk1("arst_valid", m_valid, 1'b0);
    chk1("arst_dout", m_dout, 1'b0);
    chk1("arst_done", tx_done, 1'b0);
    chk8("arst_data", data_out, 8'h00);
    bus_grant = 1'b0;
    instruction = 2'b00;
    tick;
    tick;
    chk1("arst_no_done", tx_done, 1'b0);
    reset = 1'b0;
    tick;
    write_txn(8'hC3, 1, -1, 1'b1, 1'b0);

`ifdef MASTER_TIMEOUT_EN
    instruction = 2'b00;
    tick;
    write_txn(8'h0F, 0, -1, 1'b0, 1'b0);
    repeat (9) begin
      tick;
      chk1("tmo_no_done", tx_done, 1'b0);
      chk1("tmo_busy", bus_busy, 1'b1);
    end
    tick;
    chk1("tmo_done", tx_done, 1'b1);
    chk1("tmo_err", tx_error, 1'b1);
    chk1("tmo_req_rel", bus_request, 1'b0);
    chk1("tmo_busy_rel", bus_busy, 1'b0);
    chk8("tmo_data", data_out, 8'h00);
    tick;
    chk1("tmo_done_pulse", tx_done, 1'b0);
    chk1("tmo_err_hold", tx_error, 1'b1);
    instruction = 2'b00;
    tick;
    instruction = 2'b10;
    tick;
    chk1("tmo_err_clr", tx_error, 1'b0);
    chk1("tmo_new_req", bus_request, 1'b1);
`else
    tick;
    chk1("err_tied", tx_error, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
